// File: rtl/bcd2bin_reverse_dabble_pkg.sv
// Shared constants, FSM encoding and helpers for the BCD-to-binary reverse double-dabble converter.
package bcd2bin_reverse_dabble_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] CORR_CONST  = 4'd3;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
    return digit > DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_reverse_dabble_bcd_digit_corr.sv
// One BCD digit correction slice: after a right shift, a digit of 8 or more
// carried a half-ten in from above, so 3 is taken back out.
module bcd_digit_corr
  import bcd2bin_reverse_dabble_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= CORR_THRESH) begin
      corrected = digit - CORR_CONST;
    end
  end

endmodule

// File: rtl/bcd2bin_reverse_dabble.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per cycle).
// Optional macro BCD_DIGIT_CHECK_EN adds an invalid-digit flag that zeroes the result.
module bcd2bin_reverse_dabble
  import bcd2bin_reverse_dabble_pkg::*;
#(
  parameter int N_DIGITS = 5,
  parameter int BIN_W    = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  // State | meaning
  // IDLE  | waiting for start; bcd_in captured on the accepted edge
  // SHIFT | one shift-and-correct iteration per cycle, BIN_W iterations
  // DONE  | done pulses for one cycle with bin_out updated, then IDLE

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   count;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_shift;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIN_W-1:0]       bin_shift;
  logic                   err_q;
  logic                   accept;

  assign accept    = (state == ST_IDLE) && start;
  assign shifted   = {bcd_reg, bin_reg} >> 1;
  assign bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
  assign bin_shift = shifted[BIN_W-1:0];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit     (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .corrected (bcd_next[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic any_bad;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_invalid(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
        any_bad = 1'b1;
      end
    end
  end

  // Flag survives the whole conversion so the result can be squashed at DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= any_bad;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      count   <= '0;
      bcd_reg <= '0;
      bin_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_shift;
          count   <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            bin_out <= err_q ? '0 : bin_shift;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_reverse_dabble.sv
// Directed bench for bcd2bin_reverse_dabble; define BCD_DIGIT_CHECK_EN to cover the digit check.
module tb_bcd2bin_reverse_dabble;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bcd_in;
  logic        busy;
  logic        done;
  logic [16:0] bin_out;
  logic        err;

  int n_checks;
  int n_fail;

  bcd2bin_reverse_dabble #(.N_DIGITS(5), .BIN_W(17)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one cycle, scrambles bcd_in after capture, waits (bounded) for done.
  // lat is the cycle index of done counting the first cycle after the start edge as 1.
  task automatic convert(input logic [19:0] val, output int lat, output logic [16:0] res,
                         output logic e, output int busy_low, output logic done_after,
                         output logic busy_after);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = val;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 20'h98765;
    lat = -1;
    busy_low = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!busy) busy_low++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    res = bin_out;
    e   = err;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bcd_in = 20'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (bin_out !== 17'h0) begin n_fail++; $display("FAIL reset_bin_out: got %h want 0", bin_out); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_convert();
    logic [19:0] vals [4] = '{20'h23456, 20'h12623, 20'h99999, 20'h00000};
    logic [16:0] exps [4] = '{17'h05BA0, 17'h0314F, 17'h1869F, 17'h00000};
    int lat, busy_low;
    logic [16:0] res;
    logic e, done_after, busy_after;
    for (int i = 0; i < 4; i++) begin
      convert(vals[i], lat, res, e, busy_low, done_after, busy_after);
      n_checks++;
      if (lat !== 18) begin n_fail++; $display("FAIL conv_latency[%0h]: got %0d want 18", vals[i], lat); end
      n_checks++;
      if (busy_low !== 0) begin n_fail++; $display("FAIL conv_busy[%0h]: %0d low cycles want 0", vals[i], busy_low); end
      n_checks++;
      if (res !== exps[i]) begin n_fail++; $display("FAIL conv_value[%0h]: got %h want %h", vals[i], res, exps[i]); end
      n_checks++;
      if (e !== 1'b0) begin n_fail++; $display("FAIL conv_err[%0h]: got %b want 0", vals[i], e); end
      n_checks++;
      if (done_after !== 1'b0) begin n_fail++; $display("FAIL conv_done_width[%0h]: got %b want 0", vals[i], done_after); end
      n_checks++;
      if (busy_after !== 1'b0) begin n_fail++; $display("FAIL conv_busy_release[%0h]: got %b want 0", vals[i], busy_after); end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int lat = -1;
    logic [16:0] res = '0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h23456;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h11111;
    @(negedge clk);
    start  = 1'b0;
    for (int c = 6; c < 46; c++) begin
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          res = bin_out;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignored_start_dones: got %0d want 1", dones); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL ignored_start_latency: got %0d want 18", lat); end
    n_checks++;
    if (res !== 17'h05BA0) begin n_fail++; $display("FAIL ignored_start_value: got %h want 05ba0", res); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_queue: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat, busy_low;
    logic [16:0] res;
    logic e, done_after, busy_after;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h23456;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_checks++;
    if (bin_out !== 17'h0) begin n_fail++; $display("FAIL mid_reset_bin_out: got %h want 0", bin_out); end
    for (int c = 0; c < 30; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d want 0", dones); end
    convert(20'h00042, lat, res, e, busy_low, done_after, busy_after);
    n_checks++;
    if (res !== 17'h0002A) begin n_fail++; $display("FAIL after_reset_value: got %h want 0002a", res); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 18", lat); end
  endtask

  task automatic test_rst_start();
    int dones = 0;
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b1;
    bcd_in = 20'h23456;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy: got %b want 0", busy); end
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_start_idle: %0d active cycles want 0", dones); end
  endtask

`ifdef BCD_DIGIT_CHECK_EN
  task automatic test_digit_check();
    int lat, busy_low;
    logic [16:0] res;
    logic e, done_after, busy_after;
    convert(20'h1A000, lat, res, e, busy_low, done_after, busy_after);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL check_err_set: got %b want 1", e); end
    n_checks++;
    if (res !== 17'h0) begin n_fail++; $display("FAIL check_zero_result: got %h want 0", res); end
    n_checks++;
    if (lat !== 18) begin n_fail++; $display("FAIL check_latency: got %0d want 18", lat); end
    convert(20'h00007, lat, res, e, busy_low, done_after, busy_after);
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL check_err_clear: got %b want 0", e); end
    n_checks++;
    if (res !== 17'h00007) begin n_fail++; $display("FAIL check_next_value: got %h want 00007", res); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bcd_in   = 20'h0;
    test_reset();
    test_convert();
    test_ignored_start();
    test_reset_mid();
    test_rst_start();
`ifdef BCD_DIGIT_CHECK_EN
    test_digit_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
